alct_rxd_sync_check: RTL

Checks the de-multiplexed 40 MHz ALCT receive data for the ALCT-to-TMB link synchronization test pattern. It sits directly downstream of the ALCT 80 MHz DDR de-multiplexer and consumes its 1st/2nd-in-time words. It hunts for and locks onto a counting pattern, then counts and flags bit errors. Its status feeds VME-readable registers used to tune the receive clock phase and posneg setting.

---
 rtl/alct_rxd_sync_check.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alct_rxd_sync_check.sv
// ALCT-to-TMB link sync checker: hunts for the counting/complement test pattern on the
// de-multiplexed receive words, locks onto it, then counts and flags bit errors.
module alct_rxd_sync_check #(
  parameter int WIDTH    = 16,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sync_mode,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] rxd1st,
  input  logic [WIDTH-1:0] rxd2nd,
  output logic             locked,
  output logic             sync_err,
  output logic             lost_lock,
  output logic [15:0]      err_cnt,
  output logic [15:0]      good_cnt,
  output logic [WIDTH-1:0] err_bits
);

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

  localparam logic [3:0]       LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0]       MISS_N = 4'(MISS_MAX);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] expect_word;
  logic [WIDTH-1:0] bad_bits;
  logic [3:0]       run;
  logic [3:0]       miss;
  logic [3:0]       run_inc;
  logic [3:0]       miss_inc;
  logic             cpl_ok;
  logic             seq_ok;
  logic             word_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      d1 <= rxd1st;
      d2 <= rxd2nd;
    end
  end

  assign cpl_ok   = (d2 == ~d1);
  assign seq_ok   = (d1 == expect_word);
  assign word_ok  = cpl_ok && seq_ok;
  assign run_inc  = run + 4'd1;
  assign miss_inc = miss + 4'd1;
  assign bad_bits = (d1 ^ expect_word) | (d2 ^ ~expect_word);

  // clr_err is applied last so it overrides any increment or sticky set in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      expect_word <= '0;
      run         <= '0;
      miss        <= '0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      lost_lock   <= 1'b0;
      err_cnt     <= '0;
      good_cnt    <= '0;
      err_bits    <= '0;
    end else begin
      sync_err <= 1'b0;
      if (!sync_mode) begin
        state  <= IDLE;
        run    <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= HUNT;
          end
          HUNT: begin
            if (cpl_ok) begin
              expect_word <= d1 + ONE;
              if (run == 4'd0 || seq_ok) begin
                run <= run_inc;
                if (run_inc == LOCK_N) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                  miss   <= '0;
                end
              end else begin
                run <= 4'd1;
              end
            end else begin
              run <= '0;
            end
          end
          LOCKED: begin
            // Free-running expectation keeps a single corrupted word to a single error.
            expect_word <= expect_word + ONE;
            if (word_ok) begin
              if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
              miss <= '0;
            end else begin
              sync_err <= 1'b1;
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              err_bits <= err_bits | bad_bits;
              miss     <= miss_inc;
              if (miss_inc == MISS_N) begin
                state     <= HUNT;
                run       <= '0;
                locked    <= 1'b0;
                lost_lock <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
      if (clr_err) begin
        err_cnt   <= '0;
        good_cnt  <= '0;
        err_bits  <= '0;
        lost_lock <= 1'b0;
      end
    end
  end

endmodule
